// File: rtl/accel_config_seq.sv
// Accelerometer register-write sequencer: issues a fixed write table through an SPI register writer.
// Optional soft-reset write (with settle wait) is included when ACCEL_SOFT_RESET_EN is defined.
module accel_config_seq #(
  parameter int GAP_CYCLES     = 8,
  parameter int SETTLE_CYCLES  = 500,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wr_finished,
  output logic       wr_ready,
  output logic [7:0] wr_address,
  output logic [7:0] wr_data,
  output logic       wr_reset,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int GAP_N    = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int SETTLE_N = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int TO_N     = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int MAX_A    = (GAP_N > SETTLE_N) ? GAP_N : SETTLE_N;
  localparam int MAX_N    = (MAX_A > TO_N) ? MAX_A : TO_N;
  localparam int CNT_W    = (MAX_N < 2) ? 1 : $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_N - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_N - 1);
`ifdef ACCEL_SOFT_RESET_EN
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_N - 1);
  localparam logic [1:0]       FIRST_IDX   = 2'd0;
`else
  localparam logic [1:0]       FIRST_IDX   = 2'd1;
`endif
  localparam logic [1:0]       LAST_IDX    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_RELEASE, S_SETTLE, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t           state, state_next;
  logic [1:0]       idx, idx_next;
  logic [CNT_W-1:0] cnt;
  logic             counting;

  // {address, data}; entry 0 is the soft reset and is only reachable with the macro on
  function automatic logic [15:0] entry(input logic [1:0] i);
    case (i)
      2'd0:    entry = 16'h1F52;
      2'd1:    entry = 16'h2C13;
      default: entry = 16'h2D02;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start) begin
          state_next = S_LOAD;
          idx_next   = FIRST_IDX;
        end
      S_LOAD: state_next = S_WAIT;
      // a finish arriving on the last timeout cycle still counts as success
      S_WAIT:
        if (wr_finished)         state_next = S_RELEASE;
        else if (cnt == TO_LAST) state_next = S_ERROR;
      S_RELEASE: begin
`ifdef ACCEL_SOFT_RESET_EN
        if (idx == 2'd0) state_next = S_SETTLE;
        else             state_next = S_GAP;
`else
        state_next = S_GAP;
`endif
      end
`ifdef ACCEL_SOFT_RESET_EN
      S_SETTLE:
        if (cnt == SETTLE_LAST) begin
          if (idx == LAST_IDX) state_next = S_DONE;
          else begin
            state_next = S_LOAD;
            idx_next   = idx + 2'd1;
          end
        end
`endif
      S_GAP:
        if (cnt == GAP_LAST) begin
          if (idx == LAST_IDX) state_next = S_DONE;
          else begin
            state_next = S_LOAD;
            idx_next   = idx + 2'd1;
          end
        end
      default: state_next = S_IDLE;
    endcase
  end

  assign counting = (state == S_WAIT) || (state == S_SETTLE) || (state == S_GAP);

  // counter restarts on every state change; address/data latch on the way into LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      wr_address <= 8'h00;
      wr_data    <= 8'h00;
    end else begin
      idx <= idx_next;
      if (state_next != state) cnt <= '0;
      else if (counting)       cnt <= cnt + CNT_W'(1);
      if (state_next == S_LOAD && state != S_LOAD)
        {wr_address, wr_data} <= entry(idx_next);
    end
  end

  always_comb begin
    wr_ready = 1'b0;
    wr_reset = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      S_IDLE:    wr_reset = 1'b1;
      S_LOAD:    busy     = 1'b1;
      S_WAIT:    begin busy = 1'b1; wr_ready = 1'b1; end
      S_RELEASE: begin busy = 1'b1; wr_reset = 1'b1; end
      S_SETTLE:  busy     = 1'b1;
      S_GAP:     busy     = 1'b1;
      S_DONE:    begin done  = 1'b1; wr_reset = 1'b1; end
      S_ERROR:   begin error = 1'b1; wr_reset = 1'b1; end
      default:   wr_reset = 1'b1;
    endcase
  end

endmodule

// File: doc/accel_config_seq.md
ACCEL_CONFIG_SEQ -- requirements
Module: accel_config_seq

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 8, idle cycles between consecutive writes.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 500, wait cycles after the soft-reset write.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum cycles waiting for wr_finished.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  begin configuration sequence.
REQ-007 SHALL have port wr_finished  in  1  write-done flag from the SPI register writer.
REQ-008 SHALL have port wr_ready  out  1  request to the writer to start a transaction.
REQ-009 SHALL have port wr_address  out  8  target register address.
REQ-010 SHALL have port wr_data  out  8  value to write.
REQ-011 SHALL have port wr_reset  out  1  restart of the writer, active-high.
REQ-012 SHALL have port busy  out  1  sequence in progress.
REQ-013 SHALL have port done  out  1  sequence completed, level.
REQ-014 SHALL have port error  out  1  writer timeout occurred, level.

Function
REQ-015 SHALL hold a fixed write table: entry0 0x1F<-0x52 (soft reset, macro-gated), entry1 0x2C<-0x13 (filter ctl), entry2 0x2D<-0x02 (measurement mode).
REQ-016 SHALL implement states IDLE, LOAD, WAIT, RELEASE, SETTLE, GAP, DONE, ERROR.
REQ-017 SHALL leave IDLE, DONE or ERROR for LOAD on start=1, setting entry index to first enabled entry and clearing done and error.
REQ-018 SHALL ignore start in all other states.
REQ-019 LOAD SHALL drive wr_address/wr_data from current entry, wr_reset=0, wr_ready=0, and go to WAIT next cycle.
REQ-020 WAIT SHALL drive wr_ready=1, clear-on-entry timeout counter incrementing each cycle, go to RELEASE when wr_finished=1.
REQ-021 WAIT SHALL go to ERROR when counter reaches TIMEOUT_CYCLES-1 with wr_finished=0; wr_finished wins if both same cycle.
REQ-022 wr_address/wr_data SHALL remain stable from LOAD through RELEASE.
REQ-023 RELEASE SHALL last exactly one cycle with wr_reset=1, wr_ready=0.
REQ-024 After RELEASE: soft-reset entry -> SETTLE (SETTLE_CYCLES cycles); other entries -> GAP (GAP_CYCLES cycles); wr_reset=0, wr_ready=0 in both.
REQ-025 After SETTLE/GAP: last entry -> DONE; else index+1 -> LOAD.
REQ-026 wr_reset SHALL be 1 in IDLE, RELEASE, DONE, ERROR; 0 elsewhere.
REQ-027 busy SHALL be 1 in LOAD, WAIT, RELEASE, SETTLE, GAP; done=1 only in DONE; error=1 only in ERROR.
REQ-028 GAP_CYCLES or SETTLE_CYCLES of 0 SHALL be treated as 1.
REQ-029 Counters SHALL be wide enough for largest parameter without wrap.

Reset
REQ-030 reset SHALL force IDLE immediately, index 0, counters 0.
REQ-031 Reset values: wr_ready=0, wr_address=0x00, wr_data=0x00, wr_reset=1, busy=0, done=0, error=0.
REQ-032 reset mid-transaction SHALL abort; wr_reset=1 asynchronously returns the writer to its ready state.

Configuration
REQ-033 Macro ACCEL_SOFT_RESET_EN defined: entry0 and SETTLE state included, sequence = 3 writes.
REQ-034 Macro undefined: entry0 and SETTLE omitted, sequence starts at entry1, 2 writes.

Verification
REQ-035 Macro on, start pulse, writer model asserts wr_finished 25 cycles after wr_ready -> writes 0x1F/0x52, 0x2C/0x13, 0x2D/0x02 in order, 500-cycle settle after first, done=1.
REQ-036 Macro off, same stimulus -> only 0x2C/0x13 and 0x2D/0x02 issued, 8-cycle gaps, done=1, error=0.
REQ-037 wr_finished never asserted -> error=1 exactly 64 cycles after WAIT entry, wr_reset=1, busy=0; then start -> sequence restarts, error=0.
REQ-038 reset asserted during second WAIT -> same cycle wr_reset=1, wr_ready=0, busy=0; outputs at reset values.
REQ-039 start pulsed repeatedly during GAP -> no effect; after done, start -> full sequence reruns.
REQ-040 wr_finished asserted on final timeout cycle -> RELEASE, error=0.
